// File: rtl/int_to_float_pkg.sv
// Shared FP32 field constants and the normalised-stage payload for int_to_float_pipe.
package int_to_float_pkg;

    localparam int unsigned EXP_BIAS = 127;
    localparam int unsigned EXP_W    = 8;
    localparam int unsigned MANT_W   = 23;
    localparam int unsigned FP_W     = 1 + EXP_W + MANT_W;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } fp32_t;

    // Normalised value between leading-one detect and round/pack.
    typedef struct packed {
        logic              sign;
        logic              zero;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } norm_t;

endpackage

// File: rtl/int_to_float_pipe_if.sv
// Valid/ready streaming bus for int_to_float_pipe: integer samples in, FP32 results out.
interface int_to_float_pipe_if
    import int_to_float_pkg::*;
#(
    parameter int unsigned IN_W = 16
);
    logic            in_valid;
    logic            in_ready;
    logic [IN_W-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic [FP_W-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/int_to_float_pipe_lead_zero_count.sv
// Leading-one detector: index of the most significant set bit plus an all-zero flag.
module lead_zero_count #(
    parameter  int unsigned W  = 16,
    localparam int unsigned PW = $clog2(W)
) (
    input  logic [W-1:0]  data,
    output logic [PW-1:0] pos,
    output logic          zero
);
    always_comb begin
        pos = '0;
        for (int i = 0; i < W; i++) begin
            if (data[i]) pos = PW'(i);
        end
    end

    assign zero = ~|data;
endmodule

// File: rtl/int_to_float_pipe.sv
// 3-stage integer/fixed-point to IEEE-754 single converter with global-stall handshake.
// Define INT_TO_FLOAT_ROUND_NEAREST_EN for round-to-nearest-even; default truncates.
module int_to_float_pipe
    import int_to_float_pkg::*;
#(
    parameter int unsigned IN_W      = 16,
    parameter int unsigned SIGNED_IN = 1,
    parameter int unsigned FRAC_W    = 0
) (
    input logic                clk,
    input logic                rst,
    int_to_float_pipe_if.slave bus
);
    localparam int unsigned PW = $clog2(IN_W);

    logic advance;
    assign advance      = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = advance;

    // Stage 1: sign, unsigned magnitude, zero flag.
    logic            in_sign;
    logic [IN_W-1:0] in_mag;
    logic            s1_valid, s1_sign, s1_zero;
    logic [IN_W-1:0] s1_mag;

    always_comb begin
        in_sign = (SIGNED_IN != 0) ? bus.in_data[IN_W-1] : 1'b0;
        in_mag  = in_sign ? (~bus.in_data + IN_W'(1)) : bus.in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_zero  <= 1'b0;
            s1_mag   <= '0;
        end else if (advance) begin
            s1_valid <= bus.in_valid;
            s1_sign  <= in_sign;
            s1_zero  <= ~|bus.in_data;
            s1_mag   <= in_mag;
        end
    end

    // Stage 2: locate leading one and left-align the bits below it.
    logic [PW-1:0]   lz_pos;
    logic            lz_zero;
    logic [IN_W-2:0] frac;
    norm_t           s2_next, s2;
    logic            s2_valid;

    lead_zero_count #(.W(IN_W)) u_lzc (
        .data (s1_mag),
        .pos  (lz_pos),
        .zero (lz_zero)
    );

    always_comb begin
        frac         = (IN_W-1)'(s1_mag << (PW'(IN_W-1) - lz_pos));
        s2_next      = '0;
        s2_next.sign = s1_sign;
        s2_next.zero = s1_zero || lz_zero;
        s2_next.exp  = EXP_W'(int'(EXP_BIAS) + int'(lz_pos) - int'(FRAC_W));
        s2_next.mant = MANT_W'({frac, MANT_W'(0)} >> (IN_W-1));
    end

`ifdef INT_TO_FLOAT_ROUND_NEAREST_EN
    // Bits dropped below the 23-bit fraction, offset so the slice stays legal for IN_W=2.
    logic [IN_W:0] disc;
    logic          s2_guard, s2_sticky;
    assign disc = (IN_W+1)'({frac, MANT_W'(0), 2'b00});

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_guard  <= 1'b0;
            s2_sticky <= 1'b0;
        end else if (advance) begin
            s2_guard  <= disc[IN_W];
            s2_sticky <= |disc[IN_W-1:0];
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2       <= '0;
        end else if (advance) begin
            s2_valid <= s1_valid;
            s2       <= s2_next;
        end
    end

    // Stage 3: round (optional) and pack.
    logic [MANT_W:0] mant_sum;
    fp32_t           result;

    always_comb begin
`ifdef INT_TO_FLOAT_ROUND_NEAREST_EN
        mant_sum = {1'b0, s2.mant} + (MANT_W+1)'(s2_guard && (s2_sticky || s2.mant[0]));
`else
        mant_sum = {1'b0, s2.mant};
`endif
        result      = '0;
        result.sign = s2.sign;
        result.exp  = s2.exp + EXP_W'(mant_sum[MANT_W]);
        result.mant = mant_sum[MANT_W-1:0];
        if (s2.zero) result = '0;
    end

    logic            out_valid_q;
    logic [FP_W-1:0] out_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (advance) begin
            out_valid_q <= s2_valid;
            out_data_q  <= result;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_int_to_float_pipe.sv
// Directed bench for int_to_float_pipe: three configurations share one clock and reset.
module tb_int_to_float_pipe;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    int_to_float_pipe_if #(.IN_W(16)) ia ();
    int_to_float_pipe_if #(.IN_W(16)) ib ();
    int_to_float_pipe_if #(.IN_W(32)) ic ();

    int_to_float_pipe #(.IN_W(16), .SIGNED_IN(1), .FRAC_W(0)) u_a (.clk(clk), .rst(rst), .bus(ia));
    int_to_float_pipe #(.IN_W(16), .SIGNED_IN(1), .FRAC_W(8)) u_b (.clk(clk), .rst(rst), .bus(ib));
    int_to_float_pipe #(.IN_W(32), .SIGNED_IN(1), .FRAC_W(0)) u_c (.clk(clk), .rst(rst), .bus(ic));

`ifdef INT_TO_FLOAT_ROUND_NEAREST_EN
    localparam logic [31:0] EXP_MAX32 = 32'h4F00_0000;
    localparam logic [31:0] EXP_TIE   = 32'h4B80_0002;
`else
    localparam logic [31:0] EXP_MAX32 = 32'h4EFF_FFFF;
    localparam logic [31:0] EXP_TIE   = 32'h4B80_0001;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_in(input int which, input logic v, input logic [31:0] d);
        case (which)
            0:       begin ia.in_valid = v; ia.in_data = d[15:0]; end
            1:       begin ib.in_valid = v; ib.in_data = d[15:0]; end
            default: begin ic.in_valid = v; ic.in_data = d;       end
        endcase
    endtask

    function automatic logic get_ov(input int which);
        case (which)
            0:       return ia.out_valid;
            1:       return ib.out_valid;
            default: return ic.out_valid;
        endcase
    endfunction

    function automatic logic [31:0] get_od(input int which);
        case (which)
            0:       return ia.out_data;
            1:       return ib.out_data;
            default: return ic.out_data;
        endcase
    endfunction

    function automatic logic get_ir(input int which);
        case (which)
            0:       return ia.in_ready;
            1:       return ib.in_ready;
            default: return ic.in_ready;
        endcase
    endfunction

    // Send one sample, then count cycles until the result shows up.
    task automatic convert(input int which, input logic [31:0] d, input logic [31:0] exp,
                           input string tag);
        int lat;
        set_in(which, 1'b1, d);
        @(posedge clk); #1;
        set_in(which, 1'b0, 32'h0);
        lat = 1;
        while (!get_ov(which) && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'd3);
        check(tag, get_od(which), exp);
        @(posedge clk); #1;
    endtask

    logic [31:0] exp_q [4];
    int          got, idx;
    logic        prev_stall;
    logic [31:0] prev_data;

    initial begin
        rst = 1'b1;
        for (int w = 0; w < 3; w++) set_in(w, 1'b0, 32'h0);
        ia.out_ready = 1'b1;
        ib.out_ready = 1'b1;
        ic.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        for (int w = 0; w < 3; w++) begin
            check($sformatf("rst_ov%0d", w), 32'(get_ov(w)), 32'd0);
            check($sformatf("rst_od%0d", w), get_od(w), 32'h0);
            check($sformatf("rst_ir%0d", w), 32'(get_ir(w)), 32'd1);
        end

        convert(0, 32'h0000_0001, 32'h3F80_0000, "a_pos1");
        convert(0, 32'h0000_FFFF, 32'hBF80_0000, "a_neg1");
        convert(0, 32'h0000_0000, 32'h0000_0000, "a_zero");
        convert(0, 32'h0000_8000, 32'hC700_0000, "a_min");
        convert(0, 32'h0000_7FFF, 32'h46FF_FE00, "a_max");

        convert(1, 32'h0000_0180, 32'h3FC0_0000, "b_1p5");
        convert(1, 32'h0000_FF80, 32'hBF00_0000, "b_m0p5");

        convert(2, 32'h7FFF_FFFF, EXP_MAX32, "c_max");
        convert(2, 32'd16777219,  EXP_TIE,   "c_tie");

        // Stream 1..4 with a 5-cycle downstream stall in the middle.
        exp_q      = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
        got        = 0;
        idx        = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            ia.out_ready = !(cyc >= 4 && cyc < 9);
            ia.in_valid  = (idx < 4);
            ia.in_data   = 16'(idx + 1);
            #1;
            if (ia.out_valid && !ia.out_ready) begin
                check("stall_ready", 32'(ia.in_ready), 32'd0);
                if (prev_stall) check("stall_hold", ia.out_data, prev_data);
            end
            if (ia.out_valid && ia.out_ready) begin
                if (got < 4) check($sformatf("stream%0d", got), ia.out_data, exp_q[got]);
                got++;
            end
            if (ia.in_valid && ia.in_ready) idx++;
            prev_stall = ia.out_valid && !ia.out_ready;
            prev_data  = ia.out_data;
            @(posedge clk); #1;
        end
        ia.in_valid  = 1'b0;
        ia.out_ready = 1'b1;
        check("stream_out_cnt", 32'(got), 32'd4);
        check("stream_in_cnt",  32'(idx), 32'd4);

        // Reset with two samples in flight; they must not reappear.
        ia.in_valid = 1'b1;
        ia.in_data  = 16'd7;
        repeat (2) begin @(posedge clk); #1; end
        ia.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_ov", 32'(ia.out_valid), 32'd0);
        check("midrst_ir", 32'(ia.in_ready), 32'd1);
        convert(0, 32'h0000_0005, 32'h40A0_0000, "midrst_5");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/int_to_float_pipe.md
INT_TO_FLOAT_PIPE -- requirements
Module: int_to_float_pipe

Interface
REQ-001 SHALL have parameter IN_W, default 16, meaning integer input width (legal 2..32).
REQ-002 SHALL have parameter SIGNED_IN, default 1, meaning 1 = two's-complement input, 0 = unsigned.
REQ-003 SHALL have parameter FRAC_W, default 0, meaning fixed-point fraction bits in input (legal 0..IN_W-1); result scaled by 2^-FRAC_W.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  input sample present.
REQ-007 SHALL have port in_ready  output  1  block accepts the sample this cycle.
REQ-008 SHALL have port in_data  input  IN_W  integer/fixed-point sample.
REQ-009 SHALL have port out_valid  output  1  out_data holds a result.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the result this cycle.
REQ-011 SHALL have port out_data  output  32  IEEE-754 single-precision result.

Function
REQ-012 SHALL transfer input when in_valid && in_ready, and output when out_valid && out_ready.
REQ-013 SHALL be a 3-stage pipeline: S1 sign/abs/zero-flag, S2 leading-one detect + normalise, S3 round + pack; latency exactly 3 cycles with out_ready held high.
REQ-014 SHALL sustain one sample per cycle when out_ready is high.
REQ-015 SHALL drive in_ready = !out_valid || out_ready (global stall); when stalled every stage register SHALL hold.
REQ-016 SHALL keep out_data and out_valid stable while out_valid && !out_ready.
REQ-017 SHALL compute magnitude in IN_W bits unsigned, so the most negative input -2^(IN_W-1) converts exactly.
REQ-018 SHALL set sign bit = in_data[IN_W-1] when SIGNED_IN=1, else 0.
REQ-019 SHALL set exponent field = 127 + p - FRAC_W, where p = index of the magnitude's most significant 1.
REQ-020 SHALL form the 23-bit fraction from the bits below p, left-aligned, zero-filled when p < 23.
REQ-021 SHALL output 0x00000000 for a zero input, regardless of sign mode.
REQ-022 SHALL, when rounding carries out of the fraction, clear the fraction and increment the exponent by 1.
REQ-023 SHALL never produce denormals, infinities or NaNs; the legal parameter ranges guarantee this.

Reset
REQ-024 SHALL, on rst, clear all stage valid bits and set out_valid=0 and out_data=0x00000000.
REQ-025 SHALL discard in-flight samples when rst is asserted mid-operation; the first post-reset output SHALL come from the first post-reset accepted input.
REQ-026 SHALL drive in_ready=1 on the first cycle after rst deasserts.

Configuration
REQ-027 SHALL, with macro INT_TO_FLOAT_ROUND_NEAREST_EN defined, round discarded bits (only possible when p > 23) to nearest, ties to even.
REQ-028 SHALL, without INT_TO_FLOAT_ROUND_NEAREST_EN, truncate the discarded bits toward zero in magnitude; S3 then only packs, and latency stays 3.

Structure
REQ-029 SHALL take FP32 constants (EXP_BIAS=127, EXP_W=8, MANT_W=23) from shared package int_to_float_pkg.
REQ-030 SHALL implement leading-one detection in one sub-module, lead_zero_count, parametrised by width and returning p plus an all-zero flag.

Verification
REQ-031 SHALL check IN_W=16, SIGNED_IN=1, FRAC_W=0, using only exact conversions:
- 1 -> 0x3F800000
- -1 -> 0xBF800000
- 0 -> 0x00000000
- -32768 -> 0xC7000000
- 32767 -> 0x46FFFE00
- each result appears exactly 3 cycles after acceptance.
REQ-032 SHALL check IN_W=16, FRAC_W=8: 0x0180 (1.5) -> 0x3FC00000; 0xFF80 (-0.5) -> 0xBF000000.
REQ-033 SHALL check IN_W=32, SIGNED_IN=1 with the macro defined:
- 0x7FFFFFFF -> 0x4F000000
- 16777219 -> 0x4B800002 (tie to even)
REQ-034 SHALL check the same IN_W=32 inputs without the macro: 0x7FFFFFFF -> 0x4EFFFFFF; 16777219 -> 0x4B800001.
REQ-035 SHALL check back-to-back stream 1,2,3,4 with out_ready low for 5 cycles mid-stream: no loss, no duplication, order kept, out_data stable while stalled, in_ready low while out_valid && !out_ready.
REQ-036 SHALL check rst pulsed with 2 samples in flight: out_valid=0 next cycle; the next accepted input 5 yields 0x40A00000 after 3 cycles.
